assert_monitor_multi: RTL and testbench

Parametrised multi-channel runtime assertion monitor with a free-running cycle counter. Each channel is checked against a forbidden value once the counter passes an arm threshold. Failures are recorded as per-channel pulses and sticky flags, with a saturating failure count and first-failure capture. It sits beside a DUT in simulation and gate-level regressions and is readable by bench and waveform.

---
 rtl/assert_mon_pkg.sv | 32 +++
 rtl/assert_monitor_multi_if.sv | 15 +
 rtl/assert_mon_chan.sv | 26 ++
 rtl/assert_monitor_multi.sv | 125 ++++++++++++
 tb/tb_assert_monitor_multi.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/assert_mon_pkg.sv
// Shared types and helpers for the multi-channel assertion monitor.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package assert_mon_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      TRIPPED = 2'd2
   } state_t;

   // Number of set bits in a vector of up to 32 bits.
   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n = n + {31'b0, v[i]};
      end
      return n;
   endfunction

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic int unsigned lowest_set(input logic [31:0] v);
      int unsigned idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/assert_monitor_multi_if.sv
// Control and data bus of the monitor: enable, clear, watched channels and their copy.
// Latency: none (wires only).
// Backpressure: none; the monitor accepts every cycle.
interface assert_monitor_multi_if #(
   parameter int CHANNELS = 4,
   parameter int DATA_W   = 4
);
   logic                         en;
   logic                         clr;
   logic [CHANNELS*DATA_W-1:0]   data_in;
   logic [CHANNELS*DATA_W-1:0]   data_out;

   modport master (output en, output clr, output data_in, input data_out);
   modport slave  (input en, input clr, input data_in, output data_out);
endinterface

// File: rtl/assert_mon_chan.sv
// One channel of the monitor: forbidden-value compare and sticky failure bit.
// Latency: hit is combinational; sticky updates at the next edge.
// Backpressure: none.
module assert_mon_chan #(
   parameter int                DATA_W     = 4,
   parameter logic [DATA_W-1:0] FORBID_VAL = {DATA_W{1'b1}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              chk,
   input  logic [DATA_W-1:0] data,
   output logic              hit,
   output logic              sticky
);

   assign hit = chk && (data == FORBID_VAL);

   // Sticky bit: set by any hit, only cleared by clr or reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   sticky <= 1'b0;
      else if (clr) sticky <= 1'b0;
      else if (hit) sticky <= 1'b1;
   end

endmodule

// File: rtl/assert_monitor_multi.sv
// Multi-channel runtime assertion monitor with cycle counter, sticky flags and first-failure capture.
// Latency: all status outputs register one edge after the checked cycle; armed is combinational.
// Backpressure: none; en freezes counting and checking, clr wins over en.
module assert_monitor_multi
   import assert_mon_pkg::*;
#(
   parameter int                CHANNELS   = 4,
   parameter int                DATA_W     = 4,
   parameter int                CNT_W      = 4,
   parameter int                ARM_THRESH = 10,
   parameter logic [DATA_W-1:0] FORBID_VAL = {DATA_W{1'b1}},
   parameter int                FAIL_CNT_W = 8,
   parameter int                CHAN_IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   assert_monitor_multi_if.slave bus,
   output logic [CNT_W-1:0]      cycle_cnt,
   output logic                  armed,
   output logic                  overflow_flag,
   output logic [CHANNELS-1:0]   fail_now,
   output logic [CHANNELS-1:0]   fail_sticky,
   output logic [FAIL_CNT_W-1:0] fail_count,
   output logic                  first_fail_valid,
   output logic [CHAN_IDX_W-1:0] first_fail_chan,
   output logic [CNT_W-1:0]      first_fail_cycle,
   output logic [1:0]            state
);

   localparam logic [CNT_W-1:0]      ARM_T    = CNT_W'(ARM_THRESH);
   localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [FAIL_CNT_W-1:0] FAIL_MAX = {FAIL_CNT_W{1'b1}};

   state_t                  state_q, state_d;
   logic                    chk;
   logic                    wrap;
   logic [CHANNELS-1:0]     hit;
   logic [CNT_W-1:0]        cnt_next;
   logic [31:0]             fail_sum;
   logic [FAIL_CNT_W-1:0]   fail_count_d;

   assign armed    = cycle_cnt > ARM_T;
   // clr discards the hits of its own cycle, so it masks the check here.
   assign chk      = bus.en && armed && !bus.clr;
   assign wrap     = bus.en && (cycle_cnt == CNT_MAX);
   assign cnt_next = cycle_cnt + CNT_W'(1);
   assign state    = state_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      assert_mon_chan #(
         .DATA_W     (DATA_W),
         .FORBID_VAL (FORBID_VAL)
      ) u_chan (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (bus.clr),
         .chk    (chk),
         .data   (bus.data_in[i*DATA_W +: DATA_W]),
         .hit    (hit[i]),
         .sticky (fail_sticky[i])
      );
   end

   // Saturating add of this cycle's hit count onto the running total.
   always_comb begin
      fail_sum     = 32'(fail_count) + popcount(32'(hit));
      fail_count_d = (fail_sum > 32'(FAIL_MAX)) ? FAIL_MAX : FAIL_CNT_W'(fail_sum);
   end

   // Registered copy of the watched bus, independent of en and clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.data_out <= '0;
      else        bus.data_out <= bus.data_in;
   end

   // Counter, overflow, pulse, failure total and first-failure capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt        <= '0;
         overflow_flag    <= 1'b0;
         fail_now         <= '0;
         fail_count       <= '0;
         first_fail_valid <= 1'b0;
         first_fail_chan  <= '0;
         first_fail_cycle <= '0;
      end else if (bus.clr) begin
         cycle_cnt        <= '0;
         overflow_flag    <= 1'b0;
         fail_now         <= '0;
         fail_count       <= '0;
         first_fail_valid <= 1'b0;
         first_fail_chan  <= '0;
         first_fail_cycle <= '0;
      end else begin
         fail_now <= hit;
         if (bus.en) cycle_cnt     <= cnt_next;
         if (wrap)   overflow_flag <= 1'b1;
         if (|hit)   fail_count    <= fail_count_d;
         if ((|hit) && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_chan  <= CHAN_IDX_W'(lowest_set(32'(hit)));
            first_fail_cycle <= cycle_cnt;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state: TRIPPED is terminal until clr; otherwise follow the next count.
   always_comb begin
      state_d = state_q;
      if (bus.clr) begin
         state_d = IDLE;
      end else if (bus.en) begin
         if (state_q == TRIPPED || (|hit)) state_d = TRIPPED;
         else if (cnt_next > ARM_T)        state_d = ARMED;
         else                              state_d = IDLE;
      end
   end

endmodule

// File: tb/tb_assert_monitor_multi.sv
module tb_assert_monitor_multi;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en, clr;
   logic [15:0] din;

   always #5 clk = ~clk;

   assert_monitor_multi_if #(.CHANNELS(4), .DATA_W(4)) ifa ();
   assert_monitor_multi_if #(.CHANNELS(4), .DATA_W(4)) ifb ();

   assign ifa.en = en;  assign ifa.clr = clr;  assign ifa.data_in = din;
   assign ifb.en = en;  assign ifb.clr = clr;  assign ifb.data_in = din;

   logic [3:0] a_cnt, a_ffcyc, a_now, a_sticky;
   logic       a_armed, a_ovf, a_ffv;
   logic [7:0] a_count;
   logic [1:0] a_ffc, a_state;
   logic [3:0] b_cnt, b_ffcyc, b_now, b_sticky;
   logic       b_armed, b_ovf, b_ffv;
   logic [1:0] b_count;
   logic [1:0] b_ffc, b_state;

   assert_monitor_multi dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa),
      .cycle_cnt(a_cnt), .armed(a_armed), .overflow_flag(a_ovf),
      .fail_now(a_now), .fail_sticky(a_sticky), .fail_count(a_count),
      .first_fail_valid(a_ffv), .first_fail_chan(a_ffc),
      .first_fail_cycle(a_ffcyc), .state(a_state)
   );

   assert_monitor_multi #(.FAIL_CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb),
      .cycle_cnt(b_cnt), .armed(b_armed), .overflow_flag(b_ovf),
      .fail_now(b_now), .fail_sticky(b_sticky), .fail_count(b_count),
      .first_fail_valid(b_ffv), .first_fail_chan(b_ffc),
      .first_fail_cycle(b_ffcyc), .state(b_state)
   );

   // Reference model state (plain integers, spec-level rules)
   int          m_cnt, m_ovf, m_ffv, m_ffc, m_ffcyc, m_state, m_count_a, m_count_b;
   logic [3:0]  m_now, m_sticky;
   logic [15:0] m_dout;
   int          n_checks = 0;
   int          n_fail   = 0;
   string       cur_step = "";

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s: observed=%0h expected=%0h", cur_step, name, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_ovf = 0; m_ffv = 0; m_ffc = 0; m_ffcyc = 0; m_state = 0;
      m_count_a = 0; m_count_b = 0; m_now = '0; m_sticky = '0; m_dout = '0;
   endtask

   // Apply one clock edge to the model using the inputs currently driven.
   task automatic model_edge();
      logic [3:0] h;
      int         nh;
      bit         found;
      m_dout = din;
      if (clr) begin
         m_cnt = 0; m_ovf = 0; m_ffv = 0; m_ffc = 0; m_ffcyc = 0; m_state = 0;
         m_count_a = 0; m_count_b = 0; m_now = '0; m_sticky = '0;
      end else if (en) begin
         h = '0; nh = 0; found = 0;
         if (m_cnt > 10) begin
            for (int c = 0; c < 4; c++) begin
               if (din[c*4 +: 4] == 4'hF) begin
                  h[c] = 1'b1; nh++;
                  if (!found && m_ffv == 0) begin
                     found = 1; m_ffv = 1; m_ffc = c; m_ffcyc = m_cnt;
                  end
               end
            end
         end
         m_now      = h;
         m_sticky   = m_sticky | h;
         m_count_a  = (m_count_a + nh > 255) ? 255 : m_count_a + nh;
         m_count_b  = (m_count_b + nh > 3)   ? 3   : m_count_b + nh;
         if (m_cnt == 15) begin m_cnt = 0; m_ovf = 1; end
         else m_cnt = m_cnt + 1;
         if (m_state == 2 || nh != 0) m_state = 2;
         else m_state = (m_cnt > 10) ? 1 : 0;
      end else begin
         m_now = '0;
      end
   endtask

   task automatic check_all();
      check("data_out",   ifa.data_out, m_dout);
      check("cycle_cnt",  a_cnt,    m_cnt);
      check("armed",      a_armed,  (m_cnt > 10) ? 1 : 0);
      check("overflow",   a_ovf,    m_ovf);
      check("fail_now",   a_now,    m_now);
      check("sticky",     a_sticky, m_sticky);
      check("fail_count", a_count,  m_count_a);
      check("ff_valid",   a_ffv,    m_ffv);
      check("ff_chan",    a_ffc,    m_ffc);
      check("ff_cycle",   a_ffcyc,  m_ffcyc);
      check("state",      a_state,  m_state);
      check("b_count",    b_count,  m_count_b);
      check("b_now",      b_now,    m_now);
      check("b_state",    b_state,  m_state);
      check("b_data_out", ifb.data_out, m_dout);
   endtask

   // Inputs are driven #1 after a rising edge; the model advances before the edge.
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   function automatic logic [15:0] safe_data();
      logic [15:0] d;
      for (int c = 0; c < 4; c++) d[c*4 +: 4] = 4'($urandom_range(0, 14));
      return d;
   endfunction

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (m_cnt != target && guard < 40) begin
         din = safe_data();
         step();
         guard++;
      end
      check("run_to", a_cnt, target);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; din = '0;
      model_reset();
      cur_step = "reset";
      repeat (2) @(posedge clk);
      #1;
      check_all();
      check("reset_state", a_state, 0);
      rst_n = 1'b1;
      en    = 1'b1;

      // Forbidden value before arming is ignored
      cur_step = "not_armed";
      run_to(5);
      din = safe_data(); din[11:8] = 4'hF;
      step();
      check("now_unarmed", a_now, 4'b0000);
      check("sticky_unarmed", a_sticky, 4'b0000);

      // Multi-channel hit at the first armed cycle
      cur_step = "multi_hit";
      run_to(11);
      din = 16'hF5F5;
      step();
      check("now_1010", a_now, 4'b1010);
      check("sticky_1010", a_sticky, 4'b1010);
      check("count_2", a_count, 2);
      check("ffv_1", a_ffv, 1);
      check("ffc_1", a_ffc, 1);
      check("ffcyc_11", a_ffcyc, 11);
      check("tripped", a_state, 2);
      din = 16'h5555;
      step();
      check("now_clear", a_now, 4'b0000);

      // Later failure does not overwrite the capture
      cur_step = "capture_held";
      din = 16'h555F;
      step();
      check("sticky_1011", a_sticky, 4'b1011);
      check("count_3", a_count, 3);
      check("ffc_still_1", a_ffc, 1);
      check("ffcyc_still_11", a_ffcyc, 11);

      // Wrap while tripped, then wrap from a clean state
      cur_step = "wrap";
      run_to(0);
      check("ovf_tripped", a_ovf, 1);
      check("state_tripped", a_state, 2);
      clr = 1'b1; din = safe_data(); step(); clr = 1'b0;
      for (int k = 0; k < 16; k++) begin
         din = safe_data();
         step();
      end
      check("wrap_cnt", a_cnt, 0);
      check("wrap_ovf", a_ovf, 1);
      check("wrap_armed", a_armed, 0);
      check("wrap_idle", a_state, 0);

      // Saturation on the narrow-counter instance
      cur_step = "saturate";
      clr = 1'b1; din = safe_data(); step(); clr = 1'b0;
      run_to(12);
      din = 16'hFFFF;
      step();
      check("sat_b_3", b_count, 3);
      check("sat_a_4", a_count, 4);
      din = 16'h000F;
      step();
      check("sat_b_hold", b_count, 3);
      check("sat_a_5", a_count, 5);

      // clr collides with a hit
      cur_step = "clr_collide";
      clr = 1'b1; din = safe_data(); step(); clr = 1'b0;
      run_to(11);
      din = 16'h000F; clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_now", a_now, 0);
      check("clr_sticky", a_sticky, 0);
      check("clr_count", a_count, 0);
      check("clr_ffv", a_ffv, 0);
      check("clr_cnt", a_cnt, 0);
      check("clr_idle", a_state, 0);

      // Asynchronous reset in the middle of a cycle while tripped
      cur_step = "async_rst";
      run_to(11);
      din = 16'h000F;
      step();
      check("pre_rst_trip", a_state, 2);
      din = safe_data();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      check("async_idle", a_state, 0);
      check("async_sticky", a_sticky, 0);
      #1 rst_n = 1'b1;

      // Randomized traffic with en gaps and occasional clr
      cur_step = "random";
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < 4; c++)
            din[c*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         en  = ($urandom_range(0, 9) < 8);
         clr = ($urandom_range(0, 99) < 3);
         step();
      end
      en = 1'b0; clr = 1'b0;

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
